// File: rtl/lsu_bus_ctrl_if.sv
// Data-bus side of the load/store unit: request/grant handshake plus the read-return channel.
interface lsu_bus_ctrl_if;
  logic        bus_req;
  logic        bus_gnt;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_addr, bus_we, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_addr, bus_we, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: IDLE/REQ/WAIT/DONE sequencing, byte-lane steering, load extension, timeout.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of issuing them aligned.
module lsu_bus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ls_valid,
  input  logic           ls_we,
  input  logic [1:0]     ls_size,
  input  logic           ls_unsigned,
  input  logic [31:0]    ls_addr,
  input  logic [31:0]    ls_wdata,
  output logic [31:0]    ls_rdata,
  output logic           ls_done,
  output logic           ls_stall,
  output logic           ls_err,
  lsu_bus_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  state_t      state;
  logic [15:0] cnt;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  off_q;
  logic        trap;
  logic        timeout;

  // Byte offset actually used on the bus: halves snap to addr[1], words to lane 0.
  function automatic logic [1:0] lane_off(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      2'b00:   lane_off = addr_lo;
      2'b01:   lane_off = {addr_lo[1], 1'b0};
      default: lane_off = 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   byte_en = 4'b0001 << off;
      2'b01:   byte_en = 4'b0011 << off;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   lane_wdata = {4{wd[7:0]}};
      2'b01:   lane_wdata = {2{wd[15:0]}};
      default: lane_wdata = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [1:0] size, input logic uns,
                                           input logic [1:0] off, input logic [31:0] raw);
    logic        [31:0] sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh = raw >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (size)
      2'b00:   load_ext = uns ? {24'd0, sh[7:0]}  : 32'(b);
      2'b01:   load_ext = uns ? {16'd0, sh[15:0]} : 32'(h);
      default: load_ext = sh;
    endcase
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = ((ls_size == 2'b01) && ls_addr[0]) || (ls_size[1] && (ls_addr[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  assign timeout  = (cnt + 16'd1) == TIMEOUT_LIM;
  assign ls_stall = ls_valid & ~ls_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= 16'd0;
      size_q        <= 2'b00;
      uns_q         <= 1'b0;
      off_q         <= 2'b00;
      ls_done       <= 1'b0;
      ls_err        <= 1'b0;
      ls_rdata      <= 32'd0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_be    <= 4'b0000;
      bus.bus_addr  <= 32'd0;
      bus.bus_wdata <= 32'd0;
    end else begin
      ls_done  <= 1'b0;
      ls_err   <= 1'b0;
      ls_rdata <= 32'd0;
      case (state)
        IDLE: begin
          cnt <= 16'd0;
          if (ls_valid) begin
            if (trap) begin
              state   <= DONE;
              ls_done <= 1'b1;
              ls_err  <= 1'b1;
            end else begin
              state         <= REQ;
              bus.bus_req   <= 1'b1;
              bus.bus_addr  <= {ls_addr[31:2], 2'b00};
              bus.bus_we    <= ls_we;
              bus.bus_be    <= byte_en(ls_size, lane_off(ls_size, ls_addr[1:0]));
              bus.bus_wdata <= lane_wdata(ls_size, ls_wdata);
              size_q        <= ls_size;
              uns_q         <= ls_unsigned;
              off_q         <= lane_off(ls_size, ls_addr[1:0]);
            end
          end
        end
        // Grant wins over a coincident timeout.
        REQ: begin
          if (bus.bus_gnt) begin
            bus.bus_req <= 1'b0;
            cnt         <= 16'd0;
            if (bus.bus_we) begin
              state   <= DONE;
              ls_done <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end else if (timeout) begin
            bus.bus_req <= 1'b0;
            cnt         <= 16'd0;
            state       <= DONE;
            ls_done     <= 1'b1;
            ls_err      <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WAIT: begin
          if (bus.bus_rvalid) begin
            cnt      <= 16'd0;
            state    <= DONE;
            ls_done  <= 1'b1;
            ls_rdata <= load_ext(size_q, uns_q, off_q, bus.bus_rdata);
          end else if (timeout) begin
            cnt     <= 16'd0;
            state   <= DONE;
            ls_done <= 1'b1;
            ls_err  <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DONE: begin
          cnt   <= 16'd0;
          state <= IDLE;
        end
        default: begin
          cnt   <= 16'd0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Bench for lsu_bus_ctrl: vector table driven through a bus responder, completions scored from a queue.
module tb_lsu_bus_ctrl;
  logic        clk;
  logic        rst_n;
  logic        ls_valid;
  logic        ls_we;
  logic [1:0]  ls_size;
  logic        ls_unsigned;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [31:0] ls_rdata, ls_rdata_to;
  logic        ls_done, ls_done_to;
  logic        ls_stall, ls_stall_to;
  logic        ls_err, ls_err_to;

  lsu_bus_ctrl_if bif ();
  lsu_bus_ctrl_if bif_to ();

  assign bif_to.bus_gnt    = bif.bus_gnt;
  assign bif_to.bus_rvalid = bif.bus_rvalid;
  assign bif_to.bus_rdata  = bif.bus_rdata;

  lsu_bus_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ls_valid(ls_valid), .ls_we(ls_we), .ls_size(ls_size),
    .ls_unsigned(ls_unsigned), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_rdata(ls_rdata),
    .ls_done(ls_done), .ls_stall(ls_stall), .ls_err(ls_err), .bus(bif.master)
  );

  lsu_bus_ctrl #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .rst_n(rst_n), .ls_valid(ls_valid), .ls_we(ls_we), .ls_size(ls_size),
    .ls_unsigned(ls_unsigned), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_rdata(ls_rdata_to),
    .ls_done(ls_done_to), .ls_stall(ls_stall_to), .ls_err(ls_err_to), .bus(bif_to.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic        drop;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gd;
    int          rd;
    logic [3:0]  be;
    logic [31:0] bwd;
    logic [31:0] er;
    logic        err;
    logic        trap;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  int   n_pass = 0;
  int   n_total = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns, input logic drop,
                              input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                              input int gd, input int rd, input logic [3:0] be, input logic [31:0] bwd,
                              input logic [31:0] er, input logic err, input logic trap);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.drop = drop;
    v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.gd = gd; v.rd = rd; v.be = be; v.bwd = bwd;
    v.er = er; v.err = err; v.trap = trap;
    return v;
  endfunction

  // Scoreboard: every ls_done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && ls_done) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: ls_done=1 with no request outstanding, required 0");
      end else begin
        mon_e = exp_q.pop_front();
        check($sformatf("v%0d_rdata", mon_e.id), ls_rdata, mon_e.rdata);
        check($sformatf("v%0d_err", mon_e.id), 32'(ls_err), 32'(mon_e.err));
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    ls_valid = 1'b0;
    bif.bus_gnt = 1'b0;
    bif.bus_rvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_bus_req"},   32'(bif.bus_req), 32'd0);
    check({tag, "_bus_we"},    32'(bif.bus_we), 32'd0);
    check({tag, "_bus_be"},    32'(bif.bus_be), 32'd0);
    check({tag, "_bus_addr"},  bif.bus_addr, 32'd0);
    check({tag, "_bus_wdata"}, bif.bus_wdata, 32'd0);
    check({tag, "_ls_done"},   32'(ls_done), 32'd0);
    check({tag, "_ls_err"},    32'(ls_err), 32'd0);
    check({tag, "_ls_rdata"},  ls_rdata, 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    exp_t e;
    int   cyc, nreq, gnt_cyc, exp_done;
    bit   done;
    e.id = id; e.rdata = v.er; e.err = v.err;
    exp_q.push_back(e);
    ls_valid = 1'b1; ls_we = v.we; ls_size = v.size; ls_unsigned = v.uns;
    ls_addr = v.addr; ls_wdata = v.wdata;
    cyc = 0; nreq = 0; gnt_cyc = -1; done = 1'b0;
    exp_done = v.trap ? 1 : (v.we ? v.gd + 2 : v.gd + 3 + v.rd);
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      bif.bus_gnt = 1'b0;
      bif.bus_rvalid = 1'b0;
      bif.bus_rdata = $urandom;
      if (bif.bus_req) begin
        nreq++;
        check($sformatf("v%0d_bus_addr", id), bif.bus_addr, {v.addr[31:2], 2'b00});
        check($sformatf("v%0d_bus_be", id), 32'(bif.bus_be), 32'(v.be));
        check($sformatf("v%0d_bus_wdata", id), bif.bus_wdata, v.bwd);
        check($sformatf("v%0d_bus_we", id), 32'(bif.bus_we), 32'(v.we));
        if (nreq == 1 && !v.drop) check($sformatf("v%0d_stall_req", id), 32'(ls_stall), 32'd1);
        if (nreq == v.gd + 1) begin
          bif.bus_gnt = 1'b1;
          gnt_cyc = cyc;
        end
      end
      if (!v.we && gnt_cyc > 0 && cyc == gnt_cyc + 1 + v.rd) begin
        bif.bus_rvalid = 1'b1;
        bif.bus_rdata = v.rdata;
      end
      if (ls_done) begin
        done = 1'b1;
        if (!v.drop) check($sformatf("v%0d_stall_done", id), 32'(ls_stall), 32'd0);
        check($sformatf("v%0d_latency", id), 32'(cyc), 32'(exp_done));
        ls_valid = 1'b0;
      end
      if (v.drop && cyc == 1) ls_valid = 1'b0;
    end
    if (!done) begin
      n_total++;
      $display("FAIL v%0d_done_wait: no ls_done within 40 cycles, required at cycle %0d", id, exp_done);
      do_reset();
    end else begin
      check($sformatf("v%0d_req_cycles", id), 32'(nreq), v.trap ? 32'd0 : 32'(v.gd + 1));
      @(posedge clk); #1;
      bif.bus_gnt = 1'b0;
      bif.bus_rvalid = 1'b0;
      check($sformatf("v%0d_done_pulse", id), 32'(ls_done), 32'd0);
    end
  endtask

  // Runs one load on the TIMEOUT_CYCLES=4 instance with no read return.
  task automatic to_run(input string tag, input bit give_gnt, input int exp_nreq, input int exp_done);
    int cyc, nreq;
    bit done;
    ls_valid = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_unsigned = 1'b0;
    ls_addr = 32'h100; ls_wdata = 32'h0;
    cyc = 0; nreq = 0; done = 1'b0;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      bif.bus_gnt = 1'b0;
      bif.bus_rvalid = 1'b0;
      if (bif_to.bus_req) begin
        nreq++;
        if (nreq == 1) begin
          check({tag, "_bus_addr"}, bif_to.bus_addr, 32'h100);
          check({tag, "_bus_be"}, 32'(bif_to.bus_be), 32'hF);
          check({tag, "_bus_we"}, 32'(bif_to.bus_we), 32'd0);
          check({tag, "_bus_wdata"}, bif_to.bus_wdata, 32'd0);
          if (give_gnt) bif.bus_gnt = 1'b1;
        end
      end
      if (ls_done_to) begin
        done = 1'b1;
        check({tag, "_latency"}, 32'(cyc), 32'(exp_done));
        check({tag, "_err"}, 32'(ls_err_to), 32'd1);
        check({tag, "_rdata"}, ls_rdata_to, 32'd0);
        check({tag, "_bus_req_dropped"}, 32'(bif_to.bus_req), 32'd0);
        check({tag, "_stall"}, 32'(ls_stall_to), 32'd0);
      end
    end
    if (!done) begin
      n_total++;
      $display("FAIL %s_done_wait: no ls_done within 20 cycles, required at cycle %0d", tag, exp_done);
    end
    check({tag, "_req_cycles"}, 32'(nreq), 32'(exp_nreq));
    do_reset();
  endtask

  initial begin
    vecs[0]  = mk(1'b0, 2'd2, 1'b0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
    vecs[1]  = mk(1'b0, 2'd0, 1'b0, 1'b0, 32'h103, 32'h0, 32'h80FFFFFF, 0, 0, 4'h8, 32'h0, 32'hFFFFFF80, 1'b0, 1'b0);
    vecs[2]  = mk(1'b0, 2'd0, 1'b1, 1'b0, 32'h103, 32'h0, 32'h80FFFFFF, 0, 0, 4'h8, 32'h0, 32'h00000080, 1'b0, 1'b0);
    vecs[3]  = mk(1'b1, 2'd1, 1'b0, 1'b0, 32'h202, 32'h1234ABCD, 32'h0, 5, 0, 4'hC, 32'hABCDABCD, 32'h0, 1'b0, 1'b0);
    vecs[4]  = mk(1'b1, 2'd0, 1'b0, 1'b0, 32'h301, 32'h000000A5, 32'h0, 0, 0, 4'h2, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0);
    vecs[5]  = mk(1'b1, 2'd2, 1'b0, 1'b0, 32'h400, 32'hCAFEF00D, 32'h0, 2, 0, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
    vecs[6]  = mk(1'b0, 2'd1, 1'b0, 1'b0, 32'h102, 32'h0, 32'h80017FFF, 1, 0, 4'hC, 32'h0, 32'hFFFF8001, 1'b0, 1'b0);
    vecs[7]  = mk(1'b0, 2'd1, 1'b1, 1'b0, 32'h100, 32'h0, 32'h80019ABC, 0, 2, 4'h3, 32'h0, 32'h00009ABC, 1'b0, 1'b0);
    vecs[8]  = mk(1'b0, 2'd0, 1'b0, 1'b0, 32'h100, 32'h0, 32'h1234567F, 0, 0, 4'h1, 32'h0, 32'h0000007F, 1'b0, 1'b0);
    vecs[9]  = mk(1'b0, 2'd3, 1'b0, 1'b0, 32'h104, 32'h0, 32'h0BADF00D, 0, 3, 4'hF, 32'h0, 32'h0BADF00D, 1'b0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[10] = mk(1'b0, 2'd1, 1'b0, 1'b0, 32'h101, 32'h0, 32'h12348001, 0, 0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    vecs[11] = mk(1'b0, 2'd2, 1'b0, 1'b0, 32'h106, 32'h0, 32'h11223344, 0, 0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    vecs[14] = mk(1'b1, 2'd2, 1'b0, 1'b0, 32'h203, 32'h89ABCDEF, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1);
`else
    vecs[10] = mk(1'b0, 2'd1, 1'b0, 1'b0, 32'h101, 32'h0, 32'h12348001, 0, 0, 4'h3, 32'h0, 32'hFFFF8001, 1'b0, 1'b0);
    vecs[11] = mk(1'b0, 2'd2, 1'b0, 1'b0, 32'h106, 32'h0, 32'h11223344, 0, 0, 4'hF, 32'h0, 32'h11223344, 1'b0, 1'b0);
    vecs[14] = mk(1'b1, 2'd2, 1'b0, 1'b0, 32'h203, 32'h89ABCDEF, 32'h0, 0, 0, 4'hF, 32'h89ABCDEF, 32'h0, 1'b0, 1'b0);
`endif
    vecs[12] = mk(1'b0, 2'd2, 1'b0, 1'b1, 32'h108, 32'h0, 32'h55AA55AA, 2, 1, 4'hF, 32'h0, 32'h55AA55AA, 1'b0, 1'b0);
    vecs[13] = mk(1'b1, 2'd1, 1'b0, 1'b0, 32'h200, 32'hFFFF0102, 32'h0, 1, 0, 4'h3, 32'h01020102, 32'h0, 1'b0, 1'b0);

    rst_n = 1'b0;
    ls_valid = 1'b0; ls_we = 1'b0; ls_size = 2'b00; ls_unsigned = 1'b0;
    ls_addr = 32'h0; ls_wdata = 32'h0;
    bif.bus_gnt = 1'b0; bif.bus_rvalid = 1'b0; bif.bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("por");
    rst_n = 1'b1;

    // Stray grant / read-valid while idle must not start or finish anything.
    bif.bus_gnt = 1'b1;
    bif.bus_rvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("idle_stray%0d_req", i), 32'(bif.bus_req), 32'd0);
      check($sformatf("idle_stray%0d_done", i), 32'(ls_done), 32'd0);
    end
    bif.bus_gnt = 1'b0;
    bif.bus_rvalid = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // Reset while the load sits in WAIT.
    ls_valid = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_unsigned = 1'b0; ls_addr = 32'h100; ls_wdata = 32'h0;
    @(posedge clk); #1;
    check("wrst_req", 32'(bif.bus_req), 32'd1);
    bif.bus_gnt = 1'b1;
    @(posedge clk); #1;
    bif.bus_gnt = 1'b0;
    check("wrst_in_wait", 32'(bif.bus_req), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_reset("wrst");
    ls_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check($sformatf("wrst_hold%0d_done", i), 32'(ls_done), 32'd0);
      check($sformatf("wrst_hold%0d_req", i), 32'(bif.bus_req), 32'd0);
    end
    rst_n = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    run_vec(vecs[0], 100);

    do_reset();
    to_run("to_req", 1'b0, 4, 5);
    to_run("to_wait", 1'b1, 1, 6);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/lsu_bus_ctrl.md
LSU_BUS_CTRL -- requirements
Module: lsu_bus_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: bus cycles allowed in REQ or WAIT before aborting, range 1..65535.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 ls_valid  in  1  core load/store request, held until ls_done.
REQ-005 ls_we  in  1  1 = store, 0 = load.
REQ-006 ls_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-007 ls_unsigned  in  1  1 = zero-extend load (LBU/LHU), 0 = sign-extend.
REQ-008 ls_addr  in  32  byte address.
REQ-009 ls_wdata  in  32  store data, right-aligned.
REQ-010 ls_rdata  out  32  aligned, extended load result; valid while ls_done=1.
REQ-011 ls_done  out  1  one-cycle completion pulse.
REQ-012 ls_stall  out  1  core stall = ls_valid & ~ls_done.
REQ-013 ls_err  out  1  pulses with ls_done on misalign or timeout.
REQ-014 bus_req  out  1  bus request; bus_gnt  in  1  request accepted this cycle.
REQ-015 bus_addr  out  32  {ls_addr[31:2],2'b00}; bus_we  out  1; bus_be  out  4; bus_wdata  out  32.
REQ-016 bus_rvalid  in  1  read data valid; bus_rdata  in  32  raw read word.

Function
REQ-017 FSM states IDLE, REQ, WAIT, DONE; transitions:
- IDLE -> REQ when ls_valid=1; address, size, we, unsigned, wdata registered.
- REQ -> DONE on bus_gnt if store; REQ -> WAIT on bus_gnt if load.
- WAIT -> DONE on bus_rvalid.
- DONE -> IDLE unconditionally.
REQ-018 bus_req=1 only in REQ; bus_addr/bus_we/bus_be/bus_wdata come from registers and stay stable while bus_req=1.
REQ-019 bus_be: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<(2*addr[1]); word = 4'b1111.
REQ-020 bus_wdata: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
REQ-021 Load result = bus_rdata >> (8*addr[1:0]), truncated to size, then sign- or zero-extended to 32 bits; captured in WAIT on bus_rvalid.
REQ-022 ls_done=1 and ls_rdata valid only in DONE; ls_rdata=0 for stores and errors.
REQ-023 Latency with zero-wait bus (gnt in first REQ cycle, rvalid next cycle): store done 2 cycles after IDLE accept, load done 3 cycles after.
REQ-024 A 16-bit counter clears on entry to REQ and WAIT and increments each cycle in them; when it reaches TIMEOUT_CYCLES, go to DONE with ls_err=1, bus_req dropped.
REQ-025 bus_rvalid outside WAIT and bus_gnt outside REQ are ignored.
REQ-026 ls_valid deasserting mid-transaction does not abort it; DONE is still reached.
REQ-027 A new request is accepted in IDLE the cycle after DONE; no combinational path from ls_valid to bus_req.

Reset
REQ-028 rst_n=0 forces IDLE immediately; outputs: bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, ls_done=0, ls_err=0, ls_rdata=0; counter=0.
REQ-029 Reset during REQ/WAIT abandons the access with no ls_done pulse; the first request after rst_n rises is accepted normally.

Configuration
REQ-030 Macro LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 goes IDLE -> DONE with ls_err=1, no bus_req, ls_rdata=0.
REQ-031 LSU_MISALIGN_TRAP_EN undefined: misaligned addresses are accessed at their natural alignment (half uses addr[1], word ignores addr[1:0]); ls_err comes from timeout only.

Verification
REQ-032 LW addr 0x100, gnt in first REQ cycle, rvalid next cycle with 0xDEADBEEF -> bus_be=1111, ls_rdata=0xDEADBEEF, ls_done 3 cycles after accept.
REQ-033 LB addr 0x103, rdata 0x80FF_FFFF -> bus_be=1000, ls_rdata=0xFFFFFF80; same access as LBU -> 0x00000080.
REQ-034 SH addr 0x202, wdata 0x1234ABCD, gnt delayed 5 cycles -> bus_req held 6 cycles with stable bus_addr=0x200, bus_be=1100, bus_wdata=0xABCDABCD; done 1 cycle after gnt.
REQ-035 LW with gnt but no rvalid, TIMEOUT_CYCLES=4 -> ls_done and ls_err pulse after 4 WAIT cycles, ls_rdata=0.
REQ-036 LH addr 0x101 with macro defined -> no bus_req, ls_err=1 next cycle; without macro -> bus_be=0011, extended low half returned.
REQ-037 rst_n low during WAIT -> bus_req/ls_done stay 0, state IDLE; next LW after release completes normally.
